countdown_alarm_ctrl: RTL

- Downstream consumer of the countdown timer's status flag `cd_en` (1 = counting, 0 = expired).
- Detects expiry and drives the buzzer with a burst pattern: NUM_BEEPS tone bursts separated by silent gaps.
- A user ack, a countdown restart or reset stops the alarm.
- Runs on the system clock; `cd_en` arrives from the 1 Hz tick domain and is synchronised internally.

---
 rtl/countdown_pkg.sv | 26 ++
 rtl/alarm_tone_gen.sv | 57 +++++
 rtl/countdown_alarm_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown alarm controller: FSM state encoding,
// default timing derived from the system clock rate, and a counter-width helper.
package countdown_pkg;

   localparam int CLK_HZ  = 100_000_000;
   localparam int TONE_HZ = 2_000;

   localparam int DEF_TONE_HALF_CYC = CLK_HZ / (2 * TONE_HZ);  // 25000
   localparam int DEF_ON_CYC        = CLK_HZ / 5;              // 200 ms burst
   localparam int DEF_OFF_CYC       = CLK_HZ / 5;              // 200 ms gap
   localparam int DEF_NUM_BEEPS     = 5;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARMED    = 3'd1,
      BEEP_ON  = 3'd2,
      BEEP_OFF = 3'd3,
      DONE     = 3'd4
   } alarm_state_t;

   // Bits needed for a counter running 0..n-1; never less than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// Square-wave tone source for the buzzer. The output is the value the tone
// takes after the coming edge, so the parent can register it (with muting)
// without adding a cycle of latency: in the first enabled cycle it is 1, it
// then flips every HALF_CYC cycles, and it is 0 whenever en is low.
module alarm_tone_gen
   import countdown_pkg::*;
#(
   parameter int HALF_CYC = DEF_TONE_HALF_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tone
);

   localparam int            CW   = cnt_width(HALF_CYC);
   localparam logic [CW-1:0] LAST = CW'(HALF_CYC - 1);

   logic [CW-1:0] cnt, cnt_nxt;
   logic          started, started_nxt;
   logic          tone_q;

   // Next tone phase: restart high on enable, toggle at each half-period.
   always_comb begin
      cnt_nxt     = cnt;
      started_nxt = started;
      tone        = tone_q;
      if (!en) begin
         cnt_nxt     = '0;
         started_nxt = 1'b0;
         tone        = 1'b0;
      end else if (!started) begin
         cnt_nxt     = '0;
         started_nxt = 1'b1;
         tone        = 1'b1;
      end else if (cnt == LAST) begin
         cnt_nxt = '0;
         tone    = ~tone_q;
      end else begin
         cnt_nxt = cnt + 1'b1;
      end
   end

   // Half-period counter and tone phase registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt     <= '0;
         started <= 1'b0;
         tone_q  <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         started <= started_nxt;
         tone_q  <= tone;
      end
   end

endmodule

// File: rtl/countdown_alarm_ctrl.sv
// Alarm sequencer for the countdown timer. Watches the synchronised cd_en
// flag, and when a running countdown expires plays NUM_BEEPS tone bursts
// separated by silent gaps. A restart of the countdown, a user ack or reset
// stops the alarm. state_dbg exposes the FSM state register.
module countdown_alarm_ctrl
   import countdown_pkg::*;
#(
   parameter int TONE_HALF_CYC = DEF_TONE_HALF_CYC,
   parameter int ON_CYC        = DEF_ON_CYC,
   parameter int OFF_CYC       = DEF_OFF_CYC,
   parameter int NUM_BEEPS     = DEF_NUM_BEEPS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cd_en,
   input  logic       ack,
   input  logic       mute,
   output logic       buzz,
   output logic       alarm_active,
   output logic       alarm_done,
   output logic [3:0] beep_count,
   output logic [2:0] state_dbg
);

   // One phase counter serves both the burst and the gap.
   localparam int            PW       = cnt_width((ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC);
   localparam logic [PW-1:0] ON_LAST  = PW'(ON_CYC - 1);
   localparam logic [PW-1:0] OFF_LAST = PW'(OFF_CYC - 1);
   localparam logic [3:0]    NB       = 4'(NUM_BEEPS);

   alarm_state_t  state, state_nxt;
   logic [PW-1:0] phase, phase_nxt;
   logic [3:0]    bc_nxt;
   logic          cd_meta, cd_s;
   logic          tone_en, tone;

   // Two-flop synchroniser for the slow-domain countdown flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cd_meta <= 1'b0;
         cd_s    <= 1'b0;
      end else begin
         cd_meta <= cd_en;
         cd_s    <= cd_meta;
      end
   end

   // Next-state, phase counter and burst count; restart beats ack beats expiry.
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      bc_nxt    = beep_count;
      case (state)
         IDLE: begin
            if (cd_s) state_nxt = ARMED;
         end
         ARMED: begin
            if (!cd_s) begin
               state_nxt = BEEP_ON;
               phase_nxt = '0;
               bc_nxt    = '0;
            end
         end
         BEEP_ON: begin
            if (cd_s) begin
               state_nxt = ARMED;
            end else if (ack) begin
               state_nxt = DONE;
            end else if (phase == ON_LAST) begin
               phase_nxt = '0;
               bc_nxt    = beep_count + 4'd1;
               state_nxt = (beep_count + 4'd1 == NB) ? DONE : BEEP_OFF;
            end else begin
               phase_nxt = phase + 1'b1;
            end
         end
         BEEP_OFF: begin
            if (cd_s) begin
               state_nxt = ARMED;
            end else if (ack) begin
               state_nxt = DONE;
            end else if (phase == OFF_LAST) begin
               phase_nxt = '0;
               state_nxt = BEEP_ON;
            end else begin
               phase_nxt = phase + 1'b1;
            end
         end
         DONE: begin
            if (cd_s) state_nxt = ARMED;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Tone runs only in cycles the FSM will spend in BEEP_ON.
   assign tone_en = (state_nxt == BEEP_ON);

   alarm_tone_gen #(
      .HALF_CYC (TONE_HALF_CYC)
   ) u_tone (
      .clk  (clk),
      .rst  (rst),
      .en   (tone_en),
      .tone (tone)
   );

   // FSM state, counters and the registered, mutable buzzer drive.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         phase      <= '0;
         beep_count <= '0;
         buzz       <= 1'b0;
      end else begin
         state      <= state_nxt;
         phase      <= phase_nxt;
         beep_count <= bc_nxt;
         buzz       <= tone & ~mute;
      end
   end

   // Status flags decoded straight from the state register.
   always_comb begin
      alarm_active = (state == BEEP_ON) || (state == BEEP_OFF);
      alarm_done   = (state == DONE);
      state_dbg    = state;
   end

endmodule
